// File: rtl/uart_result_tx.sv
// uart_result_tx: outbound UART for CPU result/debug words.
// Words enter through a valid/ready handshake into a small FIFO. Each word is
// sent as two 8N1 frames, high byte first.
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high
//   i_data     - 16-bit word to queue
//   i_valid    - i_data valid this cycle
//   o_ready    - FIFO not full (combinational)
//   o_tx       - registered serial line, idle high
//   o_busy     - frame in progress or FIFO non-empty
//   o_overflow - sticky: push attempted while full
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          full, empty, push, pop;

  // FSM / shifter
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          byte_sel_q, byte_sel_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          tx_q, tx_d;
  logic [7:0]    cur_byte;
  logic          baud_done;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign o_ready    = !full;
  // Acceptance ignores a same-edge pop on purpose.
  assign push       = i_valid && !full;
  assign o_overflow = ovf_q;
  assign o_tx       = tx_q;
  assign o_busy     = (state_q != IDLE) || !empty;
  assign baud_done  = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (i_valid && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + BW'(1);
    bit_d      = bit_q;
    byte_sel_d = byte_sel_q;
    shadow_d   = shadow_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop        = 1'b1;
          shadow_d   = mem_q[rptr_q];
          byte_sel_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = START;
          end else if (!empty) begin
            pop        = 1'b1;
            shadow_d   = mem_q[rptr_q];
            byte_sel_d = 1'b0;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is derived from next-state values so o_tx is a plain
  // register that changes on the same edge as the state.
  always_comb begin
    cur_byte = byte_sel_d ? shadow_d[7:0] : shadow_d[15:8];
    tx_d     = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_sel_q <= 1'b0;
      shadow_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_sel_q <= byte_sel_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: one instance at 4 clocks/bit for functional
// cases, one at 868 clocks/bit for baud timing.
module tb_uart_result_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        ready_a, tx_a, busy_a, ovf_a;
  logic        ready_b, tx_b, busy_b, ovf_b;
  logic        sel;
  logic        mon_tx, mon_busy;

  assign mon_tx   = sel ? tx_b : tx_a;
  assign mon_busy = sel ? busy_b : busy_a;

  int errors = 0;
  int checks = 0;

  uart_result_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .i_data(data_a), .i_valid(valid_a),
    .o_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a), .o_overflow(ovf_a)
  );

  uart_result_tx #(.CLKS_PER_BIT(868), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .i_data(data_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_overflow(ovf_b)
  );

  typedef struct {
    logic [15:0] data;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Called #1 after the edge on which the start bit appears; returns #1
  // after the edge that ends the second stop bit.
  task automatic check_word(input logic [7:0] hi, input logic [7:0] lo,
                            input int cpb, input string nm);
    logic [19:0] seq;
    int bad;
    logic got;
    seq = {1'b1, lo, 1'b0, 1'b1, hi, 1'b0};
    for (int b = 0; b < 20; b++) begin
      bad = 0;
      got = seq[b];
      for (int c = 0; c < cpb; c++) begin
        if (mon_tx !== seq[b] || mon_busy !== 1'b1) begin
          bad++;
          got = mon_tx;
        end
        @(posedge clk); #1;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit %0d: tx=%b busy=%b in %0d of %0d cycles, expected tx=%b busy=1",
                 nm, b, got, mon_busy, bad, cpb, seq[b]);
      end
    end
  endtask

  task automatic idle_hold(input int n, input string nm);
    int bad;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      if (mon_tx !== 1'b1 || mon_busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: line not idle in %0d of %0d cycles, expected tx=1 busy=0", nm, bad, n);
    end
  endtask

  initial begin
    vecs[0] = '{16'hA55A, 8'hA5, 8'h5A};
    vecs[1] = '{16'h1234, 8'h12, 8'h34};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[3] = '{16'h0000, 8'h00, 8'h00};
    vecs[4] = '{16'h8001, 8'h80, 8'h01};

    sel = 1'b0;
    reset = 1'b1;
    data_a = '0; valid_a = 1'b0;
    data_b = '0; valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", tx_a, 1);
    chk("reset busy", busy_a, 0);
    chk("reset ready", ready_a, 1);
    chk("reset overflow", ovf_a, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single words into an idle block
    for (int i = 0; i < 5; i++) begin
      valid_a = 1'b1;
      data_a  = vecs[i].data;
      @(posedge clk); #1;
      valid_a = 1'b0;
      data_a  = 16'hDEAD;
      chk("tx before start", tx_a, 1);
      @(posedge clk); #1;
      check_word(vecs[i].hi, vecs[i].lo, 4, "single word");
      chk("busy after word", busy_a, 0);
      idle_hold(8, "idle after word");
    end

    // Back-to-back words
    valid_a = 1'b1;
    data_a  = 16'h1234;
    @(posedge clk); #1;
    data_a  = 16'hFFFF;
    @(posedge clk); #1;
    valid_a = 1'b0;
    check_word(8'h12, 8'h34, 4, "b2b word0");
    check_word(8'hFF, 8'hFF, 4, "b2b word1");
    chk("busy after b2b", busy_a, 0);

    // Fill and overflow
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          valid_a = 1'b1;
          data_a  = 16'(k);
          @(posedge clk); #1;
        end
        chk("ready low when full", ready_a, 0);
        chk("no overflow yet", ovf_a, 0);
        data_a = 16'h0006;
        @(posedge clk); #1;
        valid_a = 1'b0;
        chk("overflow set", ovf_a, 1);
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) check_word(8'h00, 8'(k), 4, "fill word");
      end
    join
    chk("busy after fill", busy_a, 0);
    idle_hold(100, "dropped word absent");
    chk("overflow sticky", ovf_a, 1);

    // Push held across the pop edge while full
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("overflow cleared", ovf_a, 0);
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          valid_a = 1'b1;
          data_a  = {2{8'h0A + 8'(k)}};
          @(posedge clk); #1;
        end
        valid_a = 1'b0;
        chk("full before pop edge", ready_a, 0);
        repeat (76) @(posedge clk);
        #1;
        chk("no overflow before pop edge", ovf_a, 0);
        valid_a = 1'b1;
        data_a  = 16'h0BAD;
        @(posedge clk); #1;
        chk("overflow at pop edge", ovf_a, 1);
        chk("ready after pop", ready_a, 1);
        data_a = 16'h0C0D;
        @(posedge clk); #1;
        valid_a = 1'b0;
        chk("full again", ready_a, 0);
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) check_word(8'h0A + 8'(k), 8'h0A + 8'(k), 4, "popfull word");
        check_word(8'h0C, 8'h0D, 4, "popfull late word");
      end
    join
    chk("busy after popfull", busy_a, 0);
    idle_hold(40, "rejected word absent");

    // Reset mid-frame during high-byte bit 3
    valid_a = 1'b1;
    data_a  = 16'h0000;
    @(posedge clk); #1;
    data_a  = 16'h1111;
    @(posedge clk); #1;
    data_a  = 16'h2222;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("mid-frame bit3 low", tx_a, 0);
    chk("overflow before reset", ovf_a, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post-reset tx", tx_a, 1);
    chk("post-reset busy", busy_a, 0);
    chk("post-reset ready", ready_a, 1);
    chk("post-reset overflow", ovf_a, 0);
    idle_hold(200, "no frames after reset");

    // Baud timing at 868 clocks per bit
    sel = 1'b1;
    valid_b = 1'b1;
    data_b  = 16'h00FF;
    @(posedge clk); #1;
    valid_b = 1'b0;
    chk("868 tx before start", tx_b, 1);
    @(posedge clk); #1;
    check_word(8'h00, 8'hFF, 868, "baud868");
    chk("868 busy after word", busy_b, 0);
    idle_hold(20, "868 idle after word");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
